// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
//   sram_state_t     : controller FSM states
//   HM628128_*       : default timing, in cycles of a 20 ns clock
//   ns_to_cycles()   : round a datasheet time up to whole clock cycles
//   max3()           : helper for sizing the timing down-counter
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_TURN,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } sram_state_t;

  localparam int HM628128_CLK_NS   = 20;
  localparam int HM628128_RD_CYC   = 4;
  localparam int HM628128_WR_CYC   = 4;
  localparam int HM628128_TURN_CYC = 1;

  // Round up so that a datasheet minimum is never violated.
  function automatic int ns_to_cycles(input int ns, input int clk_period_ns);
    return (ns + clk_period_ns - 1) / clk_period_ns;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_async_ctrl.sv
// Controller for HM628128-class asynchronous SRAMs.
// A valid/ready request port is turned into correctly timed CE/OE/WE strobes;
// reads return data with a one-cycle rsp_valid pulse, writes with wr_ack.
// The block owns the tristate on the SRAM data bus.
//
// Parameters: AW/DW address/data width; T_RD_CYC (>=1) OE-low cycles before
// the read sample; T_WR_CYC (>=1) WE pulse width; T_TURN_CYC (>=0) idle
// cycles after a read before the next access may drive the bus.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_write, req_addr, req_wdata request contents (sampled on acceptance)
//   rsp_valid, rsp_rdata           read response (rdata held until next read)
//   wr_ack                         write completion pulse
//   busy                           controller not in IDLE
//   ram_addr, ram_dq               SRAM address and bidirectional data
//   ram_ce_, ram_we_, ram_oe_      SRAM strobes, active low
module sram_async_ctrl
  import sram_pkg::*;
#(
  parameter int AW         = 17,
  parameter int DW         = 8,
  parameter int T_RD_CYC   = HM628128_RD_CYC,
  parameter int T_WR_CYC   = HM628128_WR_CYC,
  parameter int T_TURN_CYC = HM628128_TURN_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          wr_ack,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_dq,
  output logic          ram_ce_,
  output logic          ram_we_,
  output logic          ram_oe_
);

  localparam int CW = $clog2(max3(T_RD_CYC, T_WR_CYC, T_TURN_CYC) + 1);

  sram_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          rsp_valid_reg;
  logic          wr_ack_reg;
  logic          ready_reg;
  logic          ce_reg, we_reg, oe_reg;
  logic          dq_oe_reg;
  logic          dq_oe;
  logic          load_req;
  logic          rd_done;
  logic          wr_done;
  logic          cnt_last;

  assign cnt_last = (cnt_reg == CW'(1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_req   = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Acceptance is qualified by the registered ready so nothing is
        // taken in the cycle straight after a reset edge.
        if (req_valid && ready_reg) begin
          load_req = 1'b1;
          if (req_write) begin
            state_next = WR_SETUP;
          end else begin
            state_next = RD;
            cnt_next   = CW'(T_RD_CYC);
          end
        end
      end
      RD: begin
        if (cnt_last) begin
          rd_done = 1'b1;
          if (T_TURN_CYC == 0) begin
            state_next = IDLE;
          end else begin
            state_next = RD_TURN;
            cnt_next   = CW'(T_TURN_CYC);
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      RD_TURN: begin
        if (cnt_last) state_next = IDLE;
        else          cnt_next   = cnt_reg - CW'(1);
      end
      WR_SETUP: begin
        state_next = WR_PULSE;
        cnt_next   = CW'(T_WR_CYC);
      end
      WR_PULSE: begin
        if (cnt_last) begin
          state_next = WR_HOLD;
          wr_done    = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WR_HOLD: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so the SRAM pins come
  // straight off flops and line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      wr_ack_reg    <= 1'b0;
      ready_reg     <= 1'b0;
      ce_reg        <= 1'b1;
      we_reg        <= 1'b1;
      oe_reg        <= 1'b1;
      dq_oe_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rd_done;
      wr_ack_reg    <= wr_done;
      ready_reg     <= (state_next == IDLE);
      ce_reg        <= (state_next == IDLE);
      oe_reg        <= (state_next != RD);
      we_reg        <= (state_next != WR_PULSE);
      dq_oe_reg     <= (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                       (state_next == WR_HOLD);
      if (load_req) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      // Sampled on the last OE-low edge, while the SRAM is still driving.
      if (rd_done) rdata_reg <= ram_dq;
    end
  end

  assign dq_oe     = dq_oe_reg;
  assign ram_dq    = dq_oe ? wdata_reg : 'z;
  assign req_ready = ready_reg;
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign wr_ack    = wr_ack_reg;
  assign ram_addr  = addr_reg;
  assign ram_ce_   = ce_reg;
  assign ram_we_   = we_reg;
  assign ram_oe_   = oe_reg;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: default HM628128 instance plus a narrow
// AW=8/DW=16 instance with T_RD=1, T_WR=2, T_TURN=0. Responses are checked
// by per-instance scoreboards; strobe timing is checked from cycle traces.
module tb_sram_async_ctrl;

  typedef struct packed {
    logic        is_wr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   chk = 0;
  int   err = 0;
  int   ovl = 0;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- instance A: defaults ----------------
  logic        a_req_valid, a_req_write, a_req_ready;
  logic [16:0] a_req_addr, a_ram_addr;
  logic [7:0]  a_req_wdata, a_rsp_rdata;
  logic        a_rsp_valid, a_wr_ack, a_busy;
  logic        a_ram_ce_, a_ram_we_, a_ram_oe_;
  wire  [7:0]  a_ram_dq;

  sram_async_ctrl dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .wr_ack(a_wr_ack),
    .busy(a_busy), .ram_addr(a_ram_addr), .ram_dq(a_ram_dq),
    .ram_ce_(a_ram_ce_), .ram_we_(a_ram_we_), .ram_oe_(a_ram_oe_)
  );

  // ---------------- instance B: narrow, fast ----------------
  logic        b_req_valid, b_req_write, b_req_ready;
  logic [7:0]  b_req_addr, b_ram_addr;
  logic [15:0] b_req_wdata, b_rsp_rdata;
  logic        b_rsp_valid, b_wr_ack, b_busy;
  logic        b_ram_ce_, b_ram_we_, b_ram_oe_;
  wire  [15:0] b_ram_dq;

  sram_async_ctrl #(
    .AW(8), .DW(16), .T_RD_CYC(1), .T_WR_CYC(2), .T_TURN_CYC(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .wr_ack(b_wr_ack),
    .busy(b_busy), .ram_addr(b_ram_addr), .ram_dq(b_ram_dq),
    .ram_ce_(b_ram_ce_), .ram_we_(b_ram_we_), .ram_oe_(b_ram_oe_)
  );

  // ---------------- SRAM models ----------------
  logic [7:0]  mem_a [0:131071];
  logic [15:0] mem_b [0:255];
  logic        pl_en;
  logic [16:0] pl_addr;
  logic [7:0]  pl_data;

  assign a_ram_dq = (!a_ram_ce_ && !a_ram_oe_) ? mem_a[a_ram_addr] : 'z;
  assign b_ram_dq = (!b_ram_ce_ && !b_ram_oe_) ? mem_b[b_ram_addr] : 'z;

  always @(posedge clk) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (!a_ram_ce_ && !a_ram_we_) mem_a[a_ram_addr] <= a_ram_dq;
  end
  always @(posedge clk) begin
    if (!b_ram_ce_ && !b_ram_we_) mem_b[b_ram_addr] <= b_ram_dq;
  end

  // ---------------- scoreboards ----------------
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  always @(negedge clk) begin
    if (a_rsp_valid || a_wr_ack) begin
      chk++;
      if (q_a.size() == 0) begin
        err++;
        $display("FAIL sb_a_unexpected: rsp_valid=%0b wr_ack=%0b rdata=%h, required no response",
                 a_rsp_valid, a_wr_ack, a_rsp_rdata);
      end else begin
        e_a = q_a.pop_front();
        if (e_a.is_wr ? !(a_wr_ack && !a_rsp_valid)
                      : !(a_rsp_valid && !a_wr_ack && a_rsp_rdata === e_a.data[7:0])) begin
          err++;
          $display("FAIL sb_a: rsp_valid=%0b wr_ack=%0b rdata=%h, required %s data=%h",
                   a_rsp_valid, a_wr_ack, a_rsp_rdata, e_a.is_wr ? "wr_ack" : "read", e_a.data[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rsp_valid || b_wr_ack) begin
      chk++;
      if (q_b.size() == 0) begin
        err++;
        $display("FAIL sb_b_unexpected: rsp_valid=%0b wr_ack=%0b rdata=%h, required no response",
                 b_rsp_valid, b_wr_ack, b_rsp_rdata);
      end else begin
        e_b = q_b.pop_front();
        if (e_b.is_wr ? !(b_wr_ack && !b_rsp_valid)
                      : !(b_rsp_valid && !b_wr_ack && b_rsp_rdata === e_b.data)) begin
          err++;
          $display("FAIL sb_b: rsp_valid=%0b wr_ack=%0b rdata=%h, required %s data=%h",
                   b_rsp_valid, b_wr_ack, b_rsp_rdata, e_b.is_wr ? "wr_ack" : "read", e_b.data);
        end
      end
    end
  end

  // Bus-contention watch and OE/DQ edge tracking.
  logic prev_oe_ = 1'b1;
  logic prev_dq  = 1'b0;
  int   oe_rise_cyc = 0;
  int   dq_rise_cyc = 0;
  always @(negedge clk) begin
    if (!a_ram_oe_ && dut_a.dq_oe) ovl++;
    if (!b_ram_oe_ && dut_b.dq_oe) ovl++;
    if (a_ram_oe_ && !prev_oe_) oe_rise_cyc = cyc;
    if (dut_a.dq_oe && !prev_dq) dq_rise_cyc = cyc;
    prev_oe_ = a_ram_oe_;
    prev_dq  = dut_a.dq_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns #1 after the accepting edge.
  task automatic issue_a(input logic wr, input logic [16:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input bit expect_rsp);
    int n;
    n = 0;
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
    while (a_req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      chk++; err++;
      $display("FAIL issue_a_timeout: ready=%b, required 1 within 100 cycles", a_req_ready);
    end
    if (expect_rsp) q_a.push_back('{wr, 16'(exp_rd)});
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic issue_b(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd);
    int n;
    n = 0;
    b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd;
    while (b_req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      chk++; err++;
      $display("FAIL issue_b_timeout: ready=%b, required 1 within 100 cycles", b_req_ready);
    end
    q_b.push_back('{wr, exp_rd});
    @(posedge clk); #1;
    b_req_valid = 1'b0;
  endtask

  logic [6:0] t_oe, t_rv, t_rdy, t_we, t_dq, t_ack, t_ce;
  logic [7:0] dq_mid;
  int         n, bad;
  logic [7:0] haddr;

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0;
    pl_en = 0; pl_addr = '0; pl_data = '0;

    // Preload model contents while the controller is held in reset.
    @(negedge clk); pl_en = 1; pl_addr = 17'h00123; pl_data = 8'hA5;
    @(negedge clk); pl_addr = 17'h00010; pl_data = 8'h11;
    @(negedge clk); pl_addr = 17'h00200; pl_data = 8'h22;
    @(negedge clk); pl_en = 0;

    // Reset state: {ready,rsp_valid,wr_ack,busy,ce_,we_,oe_,dq_oe}
    check("reset_a_ctl", {a_req_ready, a_rsp_valid, a_wr_ack, a_busy,
                          a_ram_ce_, a_ram_we_, a_ram_oe_, dut_a.dq_oe}, 8'b0000_1110);
    check("reset_a_rdata", 32'(a_rsp_rdata), 32'h0);
    check("reset_a_addr", 32'(a_ram_addr), 32'h0);
    check("reset_b_ctl", {b_req_ready, b_rsp_valid, b_wr_ack, b_busy,
                          b_ram_ce_, b_ram_we_, b_ram_oe_, dut_b.dq_oe}, 8'b0000_1110);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(a_req_ready), 32'h1);

    // Single read at 0x00123: OE low cycles 1..4, rsp at 5, ready at 6.
    issue_a(1'b0, 17'h00123, 8'h00, 8'hA5, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      t_oe[i] = a_ram_oe_; t_rv[i] = a_rsp_valid; t_rdy[i] = a_req_ready;
    end
    check("rd_oe_trace", 32'(t_oe), 32'b1110000);
    check("rd_rsp_trace", 32'(t_rv), 32'b0010000);
    check("rd_ready_trace", 32'(t_rdy), 32'b1100000);

    // Write 0x3C to 0x1FFFF: WE low cycles 2..5 framed by driven-bus cycles 1 and 6.
    issue_a(1'b1, 17'h1FFFF, 8'h3C, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      t_we[i] = a_ram_we_; t_dq[i] = dut_a.dq_oe; t_ack[i] = a_wr_ack;
      t_rdy[i] = a_req_ready; t_ce[i] = a_ram_ce_;
      if (i == 2) dq_mid = a_ram_dq;
    end
    check("wr_we_trace", 32'(t_we), 32'b1100001);
    check("wr_dqoe_trace", 32'(t_dq), 32'b0111111);
    check("wr_ack_trace", 32'(t_ack), 32'b0100000);
    check("wr_ready_trace", 32'(t_rdy), 32'b1000000);
    check("wr_ce_trace", 32'(t_ce), 32'b1000000);
    check("wr_dq_value", 32'(dq_mid), 32'h3C);
    check("wr_ram_addr", 32'(a_ram_addr), 32'h1FFFF);
    check("wr_mem", 32'(mem_a[17'h1FFFF]), 32'h3C);

    // Readback immediately followed by a write. OE rises at k+5, the write is
    // accepted at k+6 and drives from k+7: a gap of T_TURN_CYC+1 = 2 cycles.
    issue_a(1'b0, 17'h1FFFF, 8'h00, 8'h3C, 1'b1);
    issue_a(1'b1, 17'h00400, 8'h5A, 8'h00, 1'b1);
    issue_a(1'b0, 17'h00400, 8'h00, 8'h5A, 1'b1);
    check("turn_gap", 32'(dq_rise_cyc - oe_rise_cyc), 32'd2);
    repeat (7) @(negedge clk);

    // Request held and wiggled while busy: only the accepting edge's address counts.
    issue_a(1'b0, 17'h00010, 8'h00, 8'h11, 1'b1);
    a_req_valid = 1'b1;
    n = 0; bad = 0;
    @(negedge clk);
    while (!a_req_ready && n < 50) begin
      if (a_ram_addr !== 17'h00010) bad++;
      a_req_addr  = 17'h00100 + 17'(n);
      a_req_write = n[0];
      n++;
      @(negedge clk);
    end
    check("hold_addr_stable", 32'(bad), 32'h0);
    check("hold_busy_cycles", 32'(n), 32'd5);
    issue_a(1'b0, 17'h00200, 8'h00, 8'h22, 1'b1);
    @(negedge clk);
    check("hold_ram_addr", 32'(a_ram_addr), 32'h00200);
    repeat (7) @(negedge clk);

    // Reset in the 2nd WR_PULSE cycle; the aborted write must not acknowledge.
    issue_a(1'b1, 17'h00050, 8'h77, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_pulse", 32'(a_ram_we_), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctl", {a_req_ready, a_rsp_valid, a_wr_ack, a_busy,
                        a_ram_ce_, a_ram_we_, a_ram_oe_, dut_a.dq_oe}, 8'b0000_1110);
    check("abort_rdata", 32'(a_rsp_rdata), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(a_req_ready), 32'h1);
    repeat (6) @(negedge clk);

    // Narrow instance: fill a[i] = i+1 mod 256, then chase 300 hops from 0.
    for (int i = 0; i < 256; i++) begin
      haddr = 8'(i);
      issue_b(1'b1, haddr, 16'(8'(haddr + 8'd1)), 16'h0);
    end
    repeat (6) @(negedge clk);
    haddr = 8'h00;
    for (int h = 0; h < 300; h++) begin
      issue_b(1'b0, haddr, 16'h0, 16'(8'(haddr + 8'd1)));
      if (h == 0) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          t_oe[i] = b_ram_oe_; t_rv[i] = b_rsp_valid; t_rdy[i] = b_req_ready;
        end
        check("b_rd_oe_trace", 32'(t_oe[2:0]), 32'b110);
        check("b_rd_rsp_trace", 32'(t_rv[2:0]), 32'b010);
        check("b_rd_ready_trace", 32'(t_rdy[2:0]), 32'b110);
      end
      haddr = haddr + 8'd1;
    end

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("queues_drained", 32'(q_a.size() + q_b.size()), 32'h0);
    check("no_oe_dq_overlap", 32'(ovl), 32'h0);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/sram_async_ctrl.md
# sram_async_ctrl

Parametrised controller for asynchronous byte/word SRAMs of the HM628128 class. It generalises address and data width and makes the read, write and turnaround timings cycle-count parameters. It adds a valid/ready request port, a response strobe for reads and write acknowledges, and owns the tristate on the data bus. It sits between a request master (test sequencer, pointer-chaser, CPU bridge) and the SRAM pins.

## Interface
- AW, 17: SRAM address width.
- DW, 8: SRAM data width.
- T_RD_CYC, 4: cycles `ram_oe_` is held low before read data is latched; must be ≥1.
- T_WR_CYC, 4: cycles `ram_we_` is held low (write pulse width); must be ≥1.
- T_TURN_CYC, 1: idle cycles after a read, with `ram_oe_` high, before the next access (covers t(OHZ)); must be ≥0.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where `req_valid && req_ready`.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle pulse; `rsp_rdata` is valid.
- rsp_rdata  out  DW  read data; holds its value until the next read.
- wr_ack  out  1  one-cycle pulse when a write completes.
- busy  out  1  `state != IDLE`.
- ram_addr  out  AW  SRAM address (registered).
- ram_dq  inout  DW  SRAM data; driven only while `dq_oe` is set.
- ram_ce_  out  1  chip enable, active low.
- ram_we_  out  1  write enable, active low.
- ram_oe_  out  1  output enable, active low.

## Operation
- FSM states: IDLE, RD, RD_TURN, WR_SETUP, WR_PULSE, WR_HOLD. A down-counter of width `$clog2(max(T_RD_CYC,T_WR_CYC,T_TURN_CYC)+1)` times each state.
- IDLE:
  - `req_ready`=1; all strobes are high and `dq_oe`=0.
  - On acceptance, register `req_addr` into `ram_addr` and `req_wdata` into a write register.
  - Go to RD (counter=T_RD_CYC) or to WR_SETUP.
- RD:
  - `ram_ce_`=0 and `ram_oe_`=0 for exactly T_RD_CYC cycles.
  - On the last edge: latch `ram_dq` into `rsp_rdata`, set `rsp_valid`=1 for one cycle, and set `ram_oe_`=1.
  - Then go to RD_TURN (counter=T_TURN_CYC), or to IDLE if T_TURN_CYC=0.
- RD_TURN: `ram_ce_`=0 and `ram_oe_`=1. Go to IDLE when the count expires.
- WR_SETUP: 1 cycle. Address is stable, `dq_oe`=1, `ram_ce_`=0, `ram_we_`=1 (address setup).
- WR_PULSE: `ram_we_`=0 for exactly T_WR_CYC cycles, with `dq_oe`=1.
- WR_HOLD: 1 cycle. `ram_we_`=1, data still driven (data hold). Pulse `wr_ack`, then go to IDLE with `dq_oe`=0.
- Invariant: `ram_oe_`=0 and `dq_oe`=1 never coexist in any cycle.
- Invariant: `ram_addr` changes only in IDLE.
- `req_*` inputs are ignored outside IDLE. The master must hold them until `req_ready`.
- `rst` mid-operation:
  - Next edge: state=IDLE, all strobes high, `dq_oe`=0, pulses cleared.
  - `rsp_rdata` is cleared to 0.
  - An aborted access produces no `rsp_valid` or `wr_ack`.

## Timing
- Reset values:
  - `req_ready`=0 while `rst`=1, and 1 on the first cycle after reset.
  - `rsp_valid`=0, `rsp_rdata`=0, `wr_ack`=0, `busy`=0.
  - `ram_addr`=0, `ram_ce_`=1, `ram_we_`=1, `ram_oe_`=1, `dq_oe`=0.
- All outputs are registered. `req_ready` and `busy` are decoded from the state register.
- Read, with acceptance at edge k:
  - `ram_oe_` is low in cycles k+1 .. k+T_RD_CYC.
  - `rsp_valid` is high in cycle k+T_RD_CYC+1.
  - `req_ready` returns in cycle k+T_RD_CYC+T_TURN_CYC+1.
- Write, with acceptance at edge k:
  - `ram_we_` is low in cycles k+2 .. k+T_WR_CYC+1.
  - `wr_ack` is high in cycle k+T_WR_CYC+2.
  - `req_ready` returns in cycle k+T_WR_CYC+3.
- Back-to-back requests: a new request is accepted on the first IDLE cycle. There is no zero-bubble pipelining.

## Structure
- Package `sram_pkg`:
  - `sram_state_t` enum.
  - Function `ns_to_cycles(ns, clk_period_ns)` that rounds up, for computing the T_* parameters at instantiation.
  - Default timing constants for the HM628128 at a 20 ns clock: RD=4, WR=4, TURN=1.
- No sub-module. The tristate assignment `ram_dq = dq_oe ? wdata_q : 'z` lives in this block.
- The existing linked-list/pointer-chase sequencer is the intended first master.

## Test plan
- Single read with defaults at addr 0x00123, model returning 0xA5: `ram_oe_` low 4 cycles; `rsp_valid` 5 cycles after acceptance with `rsp_rdata`=0xA5; `req_ready` back after 6 cycles.
- Write 0x3C to 0x1FFFF, then read it back: `ram_we_` low exactly 4 cycles, framed by one high cycle each side with `ram_dq` driven; readback returns 0x3C.
- Read immediately followed by write: the bench asserts no cycle has `ram_oe_`=0 with `dq_oe`=1, and at least T_TURN_CYC cycles separate `ram_oe_` rising from `dq_oe` rising.
- Parameter sweep AW=8, DW=16, T_RD_CYC=1, T_WR_CYC=2, T_TURN_CYC=0: fill a[i]=i+1 mod 256, then pointer-chase 300 hops; every `rsp_rdata` equals the previous address+1 with wrap 255→0.
- `rst` asserted in the 2nd WR_PULSE cycle: next cycle all strobes are high, `dq_oe`=0, no `wr_ack`, `req_ready`=1 after `rst` drops.
- `req_valid` held while busy with changing `req_addr`: only the value present on the accepting edge reaches `ram_addr`.
